// File: rtl/chan_scan_seq_pkg.sv
// Shared definitions for the channel scan sequencer.
// Holds the FSM state encoding, the default select/dwell widths, the channel
// count derived from the select width and the all-zero channel mask.
package chan_scan_seq_pkg;

    localparam int SEL_W_DEF   = 3;
    localparam int DWELL_W_DEF = 8;
    localparam int NCH_DEF     = 2 ** SEL_W_DEF;

    // All-zero mask at the default channel count.
    localparam logic [NCH_DEF-1:0] MASK_ZERO = '0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_e;

    // Number of decoder channels addressed by a select of the given width.
    function automatic int nch_of(input int sel_w);
        return 2 ** sel_w;
    endfunction

endpackage

// File: rtl/chan_scan_seq_next_find.sv
// chan_next_find: combinational search for the lowest set mask bit strictly
// above a given channel index. With from_start_i=1 the search starts below
// channel 0, i.e. it returns the lowest set bit of the whole mask.
// Ports:
//   mask_i       - channel participation mask
//   idx_i        - reference channel index (ignored when from_start_i=1)
//   from_start_i - search from index -1
//   found_o      - a qualifying channel exists
//   ch_o         - lowest qualifying channel (0 when none found)
module chan_next_find
    import chan_scan_seq_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [nch_of(SEL_W)-1:0] mask_i,
    input  logic [SEL_W-1:0]         idx_i,
    input  logic                     from_start_i,
    output logic                     found_o,
    output logic [SEL_W-1:0]         ch_o
);

    localparam int NCH = nch_of(SEL_W);

    logic [NCH-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_cand
            localparam logic [SEL_W-1:0] GI = SEL_W'(gi);
            assign cand[gi] = mask_i[gi] && (from_start_i || (GI > idx_i));
        end
    endgenerate

    // Walk from the top down so the lowest candidate is the last one written.
    always_comb begin
        found_o = 1'b0;
        ch_o    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found_o = 1'b1;
                ch_o    = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/chan_scan_seq.sv
// chan_scan_seq: channel scan sequencer driving a 3-to-8 decoder.
// Steps through the channels set in a mask, holding each for dwell+1 cycles,
// in one-shot or continuous mode. All outputs are registered.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   start      - begin a scan when idle (level, sampled each edge)
//   stop       - abort the scan in progress (wins over start)
//   mode       - 0 one-shot, 1 continuous
//   ch_mask    - channels participating in the scan
//   dwell      - hold time per channel minus one
//   sel, en    - decoder select and enable
//   busy       - scan in progress
//   step       - pulse when sel is loaded with a new channel
//   done       - pulse at end of a one-shot pass or on start with empty mask
module chan_scan_seq
    import chan_scan_seq_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     mode,
    input  logic [nch_of(SEL_W)-1:0] ch_mask,
    input  logic [DWELL_W-1:0]       dwell,
    output logic [SEL_W-1:0]         sel,
    output logic                     en,
    output logic                     busy,
    output logic                     step,
    output logic                     done
);

    localparam int NCH = nch_of(SEL_W);

    state_e             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic               en_q;
    logic               busy_q;
    logic               step_q;
    logic               done_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [NCH-1:0]     mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               mode_q;

    logic               nxt_found;
    logic [SEL_W-1:0]   nxt_ch;
    logic               first_found;
    logic [SEL_W-1:0]   first_ch;

    // Next channel above the current one within the latched mask.
    chan_next_find #(.SEL_W(SEL_W)) u_find_next (
        .mask_i       (mask_q),
        .idx_i        (sel_q),
        .from_start_i (1'b0),
        .found_o      (nxt_found),
        .ch_o         (nxt_ch)
    );

    // First channel of the live mask; used at start and at a continuous wrap,
    // which are the only points where a new mask is taken.
    chan_next_find #(.SEL_W(SEL_W)) u_find_first (
        .mask_i       (ch_mask),
        .idx_i        (sel_q),
        .from_start_i (1'b1),
        .found_o      (first_found),
        .ch_o         (first_ch)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            step_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                    if (start && !stop) begin
                        // first_found is set exactly when ch_mask is non-zero.
                        if (first_found) begin
                            mask_q  <= ch_mask;
                            dwell_q <= dwell;
                            mode_q  <= mode;
                            sel_q   <= first_ch;
                            cnt_q   <= dwell;
                            en_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            step_q  <= 1'b1;
                            state_q <= ST_DWELL;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_DWELL: begin
                    if (stop) begin
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else if (nxt_found) begin
                        sel_q  <= nxt_ch;
                        cnt_q  <= dwell_q;
                        step_q <= 1'b1;
                    end else if (mode_q && first_found) begin
                        // Continuous wrap: pick up any new mask and dwell.
                        mask_q  <= ch_mask;
                        dwell_q <= dwell;
                        sel_q   <= first_ch;
                        cnt_q   <= dwell;
                        step_q  <= 1'b1;
                    end else begin
                        // End of a one-shot pass, or wrap onto an empty mask.
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel  = sel_q;
    assign en   = en_q;
    assign busy = busy_q;
    assign step = step_q;
    assign done = done_q;

endmodule

// File: tb/tb_chan_scan_seq.sv
module tb_chan_scan_seq;
    import chan_scan_seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       mode;
    logic [7:0] ch_mask;
    logic [7:0] dwell;
    logic [2:0] sel;
    logic       en;
    logic       busy;
    logic       step;
    logic       done;

    int checks_cnt;
    int errors_cnt;

    chan_scan_seq #(.DWELL_W(8), .SEL_W(3)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .ch_mask (ch_mask),
        .dwell   (dwell),
        .sel     (sel),
        .en      (en),
        .busy    (busy),
        .step    (step),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end else begin
            $display("ok   %s value=%h", tag, obs);
        end
    endtask

    // Advance one edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare packed {sel, en, busy, step, done} against expectation.
    task automatic expect_out(input string tag, input logic [2:0] e_sel, input logic e_en,
                              input logic e_busy, input logic e_step, input logic e_done);
        check(tag, {25'd0, sel, en, busy, step, done}, {25'd0, e_sel, e_en, e_busy, e_step, e_done});
    endtask

    initial begin
        logic [2:0] seq2 [5];
        logic [2:0] seq5 [6];
        checks_cnt = 0;
        errors_cnt = 0;
        seq2 = '{3'd2, 3'd5, 3'd7, 3'd2, 3'd5};
        seq5 = '{3'd2, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        ch_mask = 8'h00; dwell = 8'd0;
        #2;
        tick(); tick();
        expect_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // One-shot full mask, dwell 0.
        ch_mask = 8'hFF; dwell = 8'd0; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("oneshot c0", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            tick();
            expect_out($sformatf("oneshot c%0d", i), 3'(i), 1'b1, 1'b1, 1'b1, 1'b0);
        end
        tick();
        expect_out("oneshot end", 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("oneshot idle", 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        // Continuous sparse mask, dwell 2; start stays high to show it is ignored while busy.
        ch_mask = 8'b1010_0100; dwell = 8'd2; mode = 1'b1; start = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            expect_out($sformatf("cont c%0d", c), seq2[c/3], 1'b1, 1'b1, (c % 3) == 0, 1'b0);
        end

        // Stop at sel=5 with start still high: stop wins.
        stop = 1'b1;
        tick();
        expect_out("stop", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        tick();
        expect_out("restart", 3'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        start = 1'b0;

        // Mask change mid-pass: old pass completes, then only channel 0.
        ch_mask = 8'h01;
        for (int c = 1; c < 18; c++) begin
            tick();
            expect_out($sformatf("newmask c%0d", c), seq5[c/3], 1'b1, 1'b1, (c % 3) == 0, 1'b0);
        end

        // Stop, then one-shot {0,3} with dwell 1; reset while at sel=3.
        stop = 1'b1;
        tick();
        expect_out("stop2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        ch_mask = 8'b0000_1001; dwell = 8'd1; mode = 1'b0; start = 1'b1;
        tick();
        expect_out("rst seq c0", 3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_out("rst seq c1", 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("rst seq c2", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        expect_out("midscan reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        expect_out("post reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Empty mask start: single done pulse.
        ch_mask = MASK_ZERO; start = 1'b1;
        tick();
        expect_out("empty start", 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        expect_out("empty after", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
